wb_write_arbiter: RTL
=====================

Name: wb_write_arbiter

Overview:
- Writeback-side producer for the multi-port register file write interface (we0..we3, waddr0..3, wdata0..3).
- Accepts results from four execution lanes through valid/ready handshakes and buffers each lane in a FIFO.
- Issues at most one write per port per cycle from registered outputs.
- Enforces the file's port rules: HI/LO (address 32) writes only through port 0; no two ports write the same address in one cycle; idle ports present address 0.

Parameters:
- DEPTH, 4, entries per lane FIFO; power of two, at least 2.
- HILO_ADDR, 32, 6-bit address of the 64-bit HI/LO register.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  4  lane i offers a result.
- in_ready  out  4  lane i FIFO can accept.
- in_addr  in  24  lane i destination address in bits [6i+5:6i].
- in_data  in  256  lane i data in bits [64i+63:64i].
- we0, we1, we2, we3  out  1 each  port write enable.
- waddr0, waddr1, waddr2, waddr3  out  6 each  port write address.
- wdata0, wdata1, wdata2, wdata3  out  64 each  port write data.
- busy  out  1  any FIFO non-empty.
- err  out  1  sticky flag: an illegal address (33..63) was received.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
  - Reset values: we*=0, waddr*=0, wdata*=0, err=0.
  - All FIFOs are emptied, so busy=0 and in_ready=4'b1111 in the first cycle after reset.
  - Reset asserted mid-operation discards every pending entry; no write issues in that cycle.
- Accept:
  - in_ready[i] = (count_i != DEPTH), computed from registered count only.
  - A full FIFO does not accept in a cycle in which it pops.
  - A push occurs on the edge where in_valid[i] & in_ready[i].
- Latency:
  - An entry accepted at edge E is eligible at its lane head after E.
  - An uncontested entry drives we at edge E+1, giving a one-cycle accept-to-write latency.
- Per-cycle issue, evaluated combinationally on FIFO heads; outputs are registered.
  - Address-0 head: popped, no write, no port used.
  - Address 33..63 head: popped, no write, err set.
  - Port 0:
    - Lane 0 head, if it is a legal nonzero address (1..32).
    - Otherwise the lowest lane k in 1..3 whose head address is HILO_ADDR.
  - Port i (1..3): lane i head if its address is 1..31.
  - Lane i (1..3) head addressed to HILO_ADDR waits for port 0 and blocks lane i; lane 0 always has priority for port 0.
  - Same-address conflict: candidates are granted in lane order 0..3. A candidate whose address equals an address already granted this cycle stalls; its lane does not pop.
  - Order within a lane is strictly FIFO. Across lanes, the lower index wins on a conflict.
- Data width:
  - GPR writes (1..31): wdata[63:32] = 0, wdata[31:0] = entry[31:0].
  - HI/LO writes carry all 64 bits.
- Idle port: we=0, waddr=0, wdata=0. The file forwards wdata0 on a waddr0 match regardless of we0, so waddr0 must be 0 when idle.
- Simultaneous push and pop on a non-full FIFO: count unchanged; both take effect.
- FIFO pointers wrap modulo DEPTH.

Optional Feature:
- Macro: WB_PERF_CNT_EN.
- Defined:
  - Adds output stall_cnt (32 bits).
  - stall_cnt increments by the number of non-empty lanes that did not pop this cycle (0..4).
  - Saturates at 0xFFFFFFFF; reset to 0.
- Undefined: no port, no counter logic; behaviour otherwise identical.

Test Plan:
- Reset, then all lanes idle:
  - we*=0, waddr*=0, busy=0, in_ready=4'hF, err=0.
- Lane 2 pushes addr 5, data 0xFFFF_FFFF_1234_5678 at edge E:
  - At E+1: we2=1, waddr2=5, wdata2=0x0000_0000_1234_5678; other ports idle.
  - At E+2: we2=0.
- Lanes 0 and 1 both push addr 7 in the same cycle:
  - Next cycle: port 0 writes lane 0's data; port 1 is idle.
  - Following cycle: port 1 writes lane 1's data to addr 7.
- Lane 3 pushes addr 32, data 0xAAAA_BBBB_CCCC_DDDD while lane 0 is empty:
  - Next cycle: we0=1, waddr0=32, wdata0 equals the full 64 bits; we3=0.
  - Repeat with lane 0 holding addr 4: lane 0 goes first, HI/LO one cycle later.
- Fill lane 1 with DEPTH entries while lane 1 is blocked behind a HI/LO head and lane 0 is busy:
  - in_ready[1]=0 while full.
  - Writes drain in push order; in_ready[1]=1 after the first pop.
- Push addr 40 on lane 0, then assert rst with two entries pending on lane 2:
  - err=1 and no write for the addr-40 entry.
  - After reset: err=0, busy=0, and no write for the discarded lane-2 entries.

Source files
------------

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: four lane FIFOs feeding the register file write ports.
// Ports: clk, rst, in_valid/in_ready/in_addr/in_data (lanes 0..3),
//   we0-3/waddr0-3/wdata0-3 (registered port writes), busy, err;
//   stall_cnt when WB_PERF_CNT_EN is defined.
module wb_write_arbiter #(
  parameter int         DEPTH     = 4,
  parameter logic [5:0] HILO_ADDR = 6'd32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   in_valid,
  output logic [3:0]   in_ready,
  input  logic [23:0]  in_addr,
  input  logic [255:0] in_data,
  output logic         we0,
  output logic         we1,
  output logic         we2,
  output logic         we3,
  output logic [5:0]   waddr0,
  output logic [5:0]   waddr1,
  output logic [5:0]   waddr2,
  output logic [5:0]   waddr3,
  output logic [63:0]  wdata0,
  output logic [63:0]  wdata1,
  output logic [63:0]  wdata2,
  output logic [63:0]  wdata3,
  output logic         busy,
  output logic         err
`ifdef WB_PERF_CNT_EN
  ,
  output logic [31:0]  stall_cnt
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [5:0]  mem_a [4][DEPTH];
  logic [63:0] mem_d [4][DEPTH];
  ptr_t        rd_ptr [4];
  ptr_t        wr_ptr [4];
  cnt_t        cnt [4];

  logic [3:0]  push;
  logic [3:0]  pop;
  logic [3:0]  bad;
  logic [3:0]  nonempty;
  logic [5:0]  h_a [4];
  logic [63:0] h_d [4];

  logic [3:0]  gnt;
  logic [5:0]  g_a [4];
  logic [63:0] g_d [4];
  logic [1:0]  tgt;
  logic        hit;

  logic [3:0]  we_q;
  logic [5:0]  wa_q [4];
  logic [63:0] wd_q [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      nonempty[i] = (cnt[i] != '0);
      in_ready[i] = (cnt[i] != cnt_t'(DEPTH));
      push[i]     = in_valid[i] & in_ready[i];
      h_a[i]      = mem_a[i][rd_ptr[i]];
      h_d[i]      = mem_d[i][rd_ptr[i]];
    end
  end

  // Lanes are walked in index order so lower lanes claim ports and
  // addresses first; a HI/LO head from lanes 1..3 retargets to port 0.
  always_comb begin
    pop = '0;
    bad = '0;
    gnt = '0;
    tgt = '0;
    hit = 1'b0;
    for (int p = 0; p < 4; p++) begin
      g_a[p] = '0;
      g_d[p] = '0;
    end
    for (int i = 0; i < 4; i++) begin
      tgt = 2'(i);
      hit = 1'b0;
      if (nonempty[i]) begin
        if (h_a[i] == 6'd0) begin
          pop[i] = 1'b1;
        end else if (h_a[i] > HILO_ADDR) begin
          pop[i] = 1'b1;
          bad[i] = 1'b1;
        end else begin
          if (h_a[i] == HILO_ADDR) tgt = 2'd0;
          for (int j = 0; j < 4; j++) begin
            if (gnt[j] && (g_a[j] == h_a[i])) hit = 1'b1;
          end
          if (!gnt[tgt] && !hit) begin
            gnt[tgt] = 1'b1;
            g_a[tgt] = h_a[i];
            g_d[tgt] = (h_a[i] == HILO_ADDR) ? h_d[i]
                     : {32'd0, h_d[i][31:0]};
            pop[i]   = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        cnt[i]    <= '0;
        wa_q[i]   <= '0;
        wd_q[i]   <= '0;
      end
      we_q <= '0;
      err  <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        cnt[i]  <= cnt[i] + cnt_t'(push[i]) - cnt_t'(pop[i]);
        wa_q[i] <= g_a[i];
        wd_q[i] <= g_d[i];
      end
      we_q <= gnt;
      if (|bad) err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (push[i]) begin
        mem_a[i][wr_ptr[i]] <= in_addr[6*i +: 6];
        mem_d[i][wr_ptr[i]] <= in_data[64*i +: 64];
      end
    end
  end

`ifdef WB_PERF_CNT_EN
  logic [2:0]  n_stall;
  logic [32:0] stall_sum;

  always_comb begin
    n_stall = '0;
    for (int i = 0; i < 4; i++) begin
      n_stall = n_stall + 3'(nonempty[i] & ~pop[i]);
    end
    stall_sum = {1'b0, stall_cnt} + 33'(n_stall);
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt <= '0;
    else     stall_cnt <= stall_sum[32] ? '1 : stall_sum[31:0];
  end
`endif

  assign busy   = |nonempty;
  assign we0    = we_q[0];
  assign we1    = we_q[1];
  assign we2    = we_q[2];
  assign we3    = we_q[3];
  assign waddr0 = wa_q[0];
  assign waddr1 = wa_q[1];
  assign waddr2 = wa_q[2];
  assign waddr3 = wa_q[3];
  assign wdata0 = wd_q[0];
  assign wdata1 = wd_q[1];
  assign wdata2 = wd_q[2];
  assign wdata3 = wd_q[3];

endmodule
